// File: rtl/uart_loopback_router.sv
// APB-programmable TX->RX crossbar for NCH UART instances with per-channel
// fault injection, falling-edge counting and sticky break detection.
module uart_loopback_router #(
  parameter int NCH          = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int BREAK_CYCLES = 1024
) (
  input  logic           PCLK,
  input  logic           PRESETN,
  input  logic           PSEL,
  input  logic           PENABLE,
  input  logic           PWRITE,
  input  logic [4:0]     PADDR,
  input  logic [7:0]     PWDATA,
  output logic [7:0]     PRDATA,
  output logic           PREADY,
  output logic           PSLVERR,
  input  logic [NCH-1:0] TX_IN,
  output logic [NCH-1:0] RX_OUT,
  output logic           IRQ
);

  localparam int            CW      = $clog2(BREAK_CYCLES + 1);
  localparam logic [CW-1:0] BRK_MAX = CW'(BREAK_CYCLES);
  localparam logic [CW-1:0] BRK_PRE = CW'(BREAK_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_LOW  = 2'd1,
    MODE_HIGH = 2'd2,
    MODE_INV  = 2'd3
  } mode_e;

  logic [2:0]       ch_s;
  logic [1:0]       reg_s;
  logic             ch_ok_s;
  logic             wr_s;
  logic [NCH-1:0]   sync_q [SYNC_STAGES];
  logic [7:0]       s_pad_s;
  logic [NCH-1:0]   brk_en_s;
  logic [7:0][7:0]  chan_rd_s;
  logic             irq_q;
  logic             irq_d;

  // Line value selected by one CTRL byte; disabled or out-of-range sources idle high.
  function automatic logic route_bit(input logic [7:0] ctrl, input logic [7:0] s_pad);
    logic v;
    v = s_pad[ctrl[2:0]];
    if (!ctrl[7]) begin
      route_bit = 1'b1;
    end else if ({1'b0, ctrl[2:0]} >= 4'(NCH)) begin
      route_bit = 1'b1;
    end else begin
      case (mode_e'(ctrl[4:3]))
        MODE_PASS: route_bit = v;
        MODE_LOW:  route_bit = 1'b0;
        MODE_HIGH: route_bit = 1'b1;
        MODE_INV:  route_bit = ~v;
        default:   route_bit = 1'b1;
      endcase
    end
  endfunction

  assign ch_s    = PADDR[4:2];
  assign reg_s   = PADDR[1:0];
  assign ch_ok_s = ({1'b0, ch_s} < 4'(NCH));
  assign wr_s    = PSEL & PENABLE & PWRITE & ch_ok_s;
  assign s_pad_s = 8'(sync_q[SYNC_STAGES-1]);
  assign PREADY  = 1'b1;
  assign PSLVERR = PSEL & PENABLE & ~ch_ok_s;

  // TX synchroniser chain, idles high so a reset never looks like a start bit
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '1;
      end
    end else begin
      sync_q[0] <= TX_IN;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [7:0]    ctrl_q;
    logic [7:0]    ctrl_d;
    logic          brk_q;
    logic          brk_d;
    logic [7:0]    edges_q;
    logic [7:0]    edges_d;
    logic [CW-1:0] low_q;
    logic [CW-1:0] low_d;
    logic          rx_q;
    logic          rx_d;
    logic          rx_prev_q;
    logic          sel_s;
    logic          fall_s;
    logic          set_s;
    logic          clr_s;

    assign sel_s  = wr_s && (ch_s == 3'(c));
    assign fall_s = rx_prev_q & ~rx_q;
    assign set_s  = ~rx_q & (low_q == BRK_PRE);
    assign clr_s  = sel_s && (reg_s == 2'd1) && PWDATA[0];

    // Next-state for the channel: route, control, break monitor and edge count
    always_comb begin
      rx_d = route_bit(ctrl_q, s_pad_s);
      if (sel_s && (reg_s == 2'd0)) begin
        ctrl_d = PWDATA & 8'hDF;
      end else begin
        ctrl_d = ctrl_q;
      end
      if (rx_q) begin
        low_d = {CW{1'b0}};
      end else if (low_q == BRK_MAX) begin
        low_d = low_q;
      end else begin
        low_d = low_q + CW'(1);
      end
      brk_d = set_s | (brk_q & ~clr_s);
      if (sel_s && (reg_s == 2'd2)) begin
        edges_d = 8'h00;
      end else if (fall_s && (edges_q != 8'hFF)) begin
        edges_d = edges_q + 8'd1;
      end else begin
        edges_d = edges_q;
      end
    end

    // Channel state registers; the RX line and its history reset to idle high
    always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
        ctrl_q    <= 8'h00;
        brk_q     <= 1'b0;
        edges_q   <= 8'h00;
        low_q     <= {CW{1'b0}};
        rx_q      <= 1'b1;
        rx_prev_q <= 1'b1;
      end else begin
        ctrl_q    <= ctrl_d;
        brk_q     <= brk_d;
        edges_q   <= edges_d;
        low_q     <= low_d;
        rx_q      <= rx_d;
        rx_prev_q <= rx_q;
      end
    end

    assign RX_OUT[c]    = rx_q;
    assign brk_en_s[c]  = brk_q & ctrl_q[6];
    assign chan_rd_s[c] = (reg_s == 2'd0) ? ctrl_q :
                          (reg_s == 2'd1) ? {6'b000000, rx_q, brk_q} :
                          (reg_s == 2'd2) ? edges_q : 8'h00;
  end

  for (genvar c = NCH; c < 8; c++) begin : g_pad
    assign chan_rd_s[c] = 8'h00;
  end

  assign irq_d = |brk_en_s;

  // Registered interrupt from the enabled break flags
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign IRQ = irq_q;

  // Combinational APB read mux, quiet when not selected
  always_comb begin
    if (PSEL && ch_ok_s) begin
      PRDATA = chan_rd_s[ch_s];
    end else begin
      PRDATA = 8'h00;
    end
  end

endmodule

// File: tb/tb_uart_loopback_router.sv
// Directed bench for uart_loopback_router: a 4-channel instance for the functional
// scenarios and a 2-channel instance sharing the bus for the reset address sweep.
`timescale 1ns/1ps
module tb_uart_loopback_router;

  localparam int NCH  = 4;
  localparam int BRKC = 16;

  logic           PCLK    = 1'b0;
  logic           PRESETN = 1'b0;
  logic           PSEL    = 1'b0;
  logic           PENABLE = 1'b0;
  logic           PWRITE  = 1'b0;
  logic [4:0]     PADDR   = 5'd0;
  logic [7:0]     PWDATA  = 8'h00;
  logic [NCH-1:0] TX_IN   = '1;
  logic [7:0]     PRDATA, PRDATA2;
  logic           PREADY, PREADY2, PSLVERR, PSLVERR2, IRQ, IRQ2;
  logic [NCH-1:0] RX_OUT;
  logic [1:0]     RX_OUT2;

  int total = 0;
  int bad   = 0;
  logic [7:0] rd4, rd2;
  logic       er4, er2;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] rdata;
    logic       slverr;
  } rd_vec_t;

  typedef struct {
    logic [7:0] ctrl;
    logic [3:0] tx;
    logic       rx;
  } mode_vec_t;

  rd_vec_t   sweep2 [32];
  rd_vec_t   sweep4 [32];
  mode_vec_t mv     [14];

  always #5 PCLK = ~PCLK;

  uart_loopback_router #(.NCH(NCH), .SYNC_STAGES(2), .BREAK_CYCLES(BRKC)) u_dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .TX_IN(TX_IN), .RX_OUT(RX_OUT), .IRQ(IRQ)
  );

  uart_loopback_router #(.NCH(2), .SYNC_STAGES(2), .BREAK_CYCLES(BRKC)) u_dut2 (
    .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA2), .PREADY(PREADY2), .PSLVERR(PSLVERR2),
    .TX_IN(TX_IN[1:0]), .RX_OUT(RX_OUT2), .IRQ(IRQ2)
  );

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; the write is sampled two rising edges later.
  task automatic apb_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [4:0] a);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = a;
    #1;
    rd4 = PRDATA; er4 = PSLVERR; rd2 = PRDATA2; er2 = PSLVERR2;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  initial begin
    logic [9:0]  frame_v;
    logic [63:0] hist;
    logic        txv;
    logic        exp_rx;

    // STATUS bit 1 mirrors the idle-high RX line, so it reads 0x02 out of reset.
    for (int i = 0; i < 32; i++) begin
      sweep2[i].addr   = 5'(i);
      sweep2[i].rdata  = ((i / 4) < 2 && (i % 4) == 1) ? 8'h02 : 8'h00;
      sweep2[i].slverr = (i >= 8);
      sweep4[i].addr   = 5'(i);
      sweep4[i].rdata  = ((i / 4) < 4 && (i % 4) == 1) ? 8'h02 : 8'h00;
      sweep4[i].slverr = (i >= 16);
    end
    mv[0]  = '{8'h00, 4'b0000, 1'b1};
    mv[1]  = '{8'h80, 4'b0000, 1'b0};
    mv[2]  = '{8'h80, 4'b0001, 1'b1};
    mv[3]  = '{8'h81, 4'b0001, 1'b0};
    mv[4]  = '{8'h81, 4'b0010, 1'b1};
    mv[5]  = '{8'h83, 4'b0111, 1'b0};
    mv[6]  = '{8'h83, 4'b1000, 1'b1};
    mv[7]  = '{8'h88, 4'b1111, 1'b0};
    mv[8]  = '{8'h90, 4'b0000, 1'b1};
    mv[9]  = '{8'h98, 4'b0001, 1'b0};
    mv[10] = '{8'h98, 4'b0000, 1'b1};
    mv[11] = '{8'h84, 4'b0000, 1'b1};
    mv[12] = '{8'h1F, 4'b0000, 1'b1};
    mv[13] = '{8'hE2, 4'b0100, 1'b1};

    tick(3);
    check8("reset_rx4", 8'(RX_OUT), 8'h0F);
    check8("reset_rx2", 8'(RX_OUT2), 8'h03);
    check8("reset_irq", {6'b0, IRQ2, IRQ}, 8'h00);
    check8("reset_prdata", PRDATA, 8'h00);
    check8("reset_slverr", 8'(PSLVERR), 8'h00);
    check8("pready", {6'b0, PREADY2, PREADY}, 8'h03);
    @(negedge PCLK);
    PRESETN = 1'b1;
    tick(1);

    for (int i = 0; i < 32; i++) begin
      apb_read(sweep2[i].addr);
      check8($sformatf("sweep2_rd_a%0d", i), rd2, sweep2[i].rdata);
      check8($sformatf("sweep2_err_a%0d", i), 8'(er2), 8'(sweep2[i].slverr));
    end
    PADDR = 5'd1;
    #1;
    check8("prdata_unselected", PRDATA2, 8'h00);

    // Route and fault-mode table on channel 3
    for (int i = 0; i < 14; i++) begin
      tick(1);
      TX_IN = mv[i].tx;
      apb_write(5'd12, mv[i].ctrl);
      tick(3);
      check8($sformatf("mode_rx3_v%0d", i), 8'(RX_OUT[3]), 8'(mv[i].rx));
      apb_read(5'd13);
      check8($sformatf("mode_status3_v%0d", i), rd4, {6'b0, mv[i].rx, 1'b0});
      apb_read(5'd12);
      check8($sformatf("mode_ctrl3_v%0d", i), rd4, mv[i].ctrl & 8'hDF);
    end
    check8("irq_no_brk", 8'(IRQ), 8'h00);
    apb_write(5'd12, 8'h00);
    apb_write(5'd14, 8'h00);
    TX_IN = '1;

    // 0x55 8N1 frame on TX_IN[0], 4 cycles per bit, routed to RX_OUT[1]
    apb_write(5'd4, 8'h80);
    tick(3);
    frame_v = {1'b1, 8'h55, 1'b0};
    hist = '1;
    for (int k = 0; k < 52; k++) begin
      @(posedge PCLK);
      #1;
      exp_rx = (k >= 3) ? hist[k-3] : 1'b1;
      check8($sformatf("delay3_k%0d", k), 8'(RX_OUT[1]), 8'(exp_rx));
      txv = (k < 4 || k >= 44) ? 1'b1 : frame_v[(k - 4) / 4];
      TX_IN[0] = txv;
      hist[k] = txv;
    end
    tick(4);
    apb_read(5'd6);
    check8("edges_0x55", rd4, 8'h05);
    apb_read(5'd5);
    check8("status1_idle", rd4, 8'h02);

    // Break injection and detection
    apb_write(5'd4, 8'h88);
    check8("brk_rx_old_route", 8'(RX_OUT[1]), 8'h01);
    tick(1);
    check8("brk_rx_low", 8'(RX_OUT[1]), 8'h00);
    tick(15);
    apb_read(5'd5);
    check8("brk_before_16", rd4, 8'h00);
    tick(1);
    apb_read(5'd5);
    check8("brk_at_16", rd4, 8'h01);
    check8("irq_masked", 8'(IRQ), 8'h00);
    tick(4);
    check8("irq_masked_later", 8'(IRQ), 8'h00);
    apb_write(5'd4, 8'hC8);
    check8("irq_en_lat1", 8'(IRQ), 8'h00);
    tick(1);
    check8("irq_en_lat2", 8'(IRQ), 8'h01);

    // Clearing while the line stays low must not re-arm the flag
    apb_write(5'd5, 8'h01);
    apb_read(5'd5);
    check8("brk_clr_low", rd4, 8'h00);
    check8("irq_hold_after_clr", 8'(IRQ), 8'h01);
    tick(1);
    check8("irq_drop_after_clr", 8'(IRQ), 8'h00);
    tick(20);
    apb_read(5'd5);
    check8("brk_no_reset_while_low", rd4, 8'h00);

    // Set and write-1-clear on the same edge
    apb_write(5'd4, 8'hC0);
    tick(2);
    check8("rx_high_mode0", 8'(RX_OUT[1]), 8'h01);
    apb_write(5'd4, 8'hC8);
    tick(15);
    apb_write(5'd5, 8'h01);
    apb_read(5'd5);
    check8("brk_set_wins", rd4, 8'h01);
    tick(1);
    check8("irq_after_set", 8'(IRQ), 8'h01);
    apb_write(5'd5, 8'h00);
    apb_read(5'd5);
    check8("brk_write0", rd4, 8'h01);
    apb_write(5'd4, 8'hC0);
    apb_write(5'd5, 8'h01);
    apb_read(5'd5);
    check8("brk_clr_high", rd4, 8'h02);
    check8("irq_clr_lat0", 8'(IRQ), 8'h01);
    tick(1);
    check8("irq_clr_lat1", 8'(IRQ), 8'h00);

    // Edge counter saturation through invert mode
    TX_IN[0] = 1'b0;
    apb_write(5'd4, 8'h98);
    tick(4);
    apb_write(5'd6, 8'h00);
    tick(2);
    apb_read(5'd6);
    check8("edges_cleared", rd4, 8'h00);
    for (int i = 0; i < 100; i++) begin
      tick(1);
      TX_IN[0] = ~TX_IN[0];
    end
    tick(5);
    apb_read(5'd6);
    check8("edges_50", rd4, 8'h32);
    for (int i = 0; i < 500; i++) begin
      tick(1);
      TX_IN[0] = ~TX_IN[0];
    end
    tick(5);
    apb_read(5'd6);
    check8("edges_saturate", rd4, 8'hFF);

    // EDGES write lands on the same edge as an increment
    tick(1);
    TX_IN[0] = 1'b1;
    tick(2);
    apb_write(5'd6, 8'h00);
    apb_read(5'd6);
    check8("edges_clear_wins", rd4, 8'h00);
    tick(3);
    apb_read(5'd6);
    check8("edges_no_late_incr", rd4, 8'h00);

    // Out-of-range source, then asynchronous reset mid-frame
    tick(1);
    TX_IN = '0;
    apb_write(5'd0, 8'h87);
    apb_write(5'd8, 8'h80);
    tick(3);
    check8("src7_idle", 8'(RX_OUT[0]), 8'h01);
    check8("rx2_routed_low", 8'(RX_OUT[2]), 8'h00);
    apb_read(5'd0);
    check8("ctrl0_readback", rd4, 8'h87);
    @(posedge PCLK);
    #2;
    PRESETN = 1'b0;
    #1;
    check8("async_reset_rx", 8'(RX_OUT), 8'h0F);
    check8("async_reset_irq", 8'(IRQ), 8'h00);
    tick(2);
    @(negedge PCLK);
    PRESETN = 1'b1;
    TX_IN = '1;
    tick(1);
    for (int i = 0; i < 32; i++) begin
      apb_read(sweep4[i].addr);
      check8($sformatf("sweep4_rd_a%0d", i), rd4, sweep4[i].rdata);
      check8($sformatf("sweep4_err_a%0d", i), 8'(er4), 8'(sweep4[i].slverr));
    end
    check8("post_reset_rx", 8'(RX_OUT), 8'h0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
